// File: rtl/id_stage.sv
// id_stage: decode/register-read stage with a pending-write scoreboard feeding one registered ALU slot.
module id_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [15:0]       instr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [3:0]        func4_o,
  output logic              imm_en_o,
  output logic [2:0]        rd_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  input  logic              wb_en_i,
  input  logic [2:0]        wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              illegal_o,
  output logic              busy_o
);
  logic [DATA_W-1:0] rf_q [8];
  logic [7:0] pend_q, pend_eff, wb_mask, set_mask;
  logic [DATA_W-1:0] rs1_q, rs2_q, imm_q, rs1_val, rs2_val, imm_val;
  logic [3:0] func4_q;
  logic imm_en_q, out_valid_q, illegal_q;
  logic [2:0] rd_q;
  logic ie, legal, hazard, accept;
  logic [3:0] f4;
  logic [2:0] rd, rs1, rs2;
  assign ie  = instr_i[15];
  assign f4  = instr_i[14:11];
  assign rd  = instr_i[10:8];
  assign rs1 = instr_i[7:5];
  assign rs2 = instr_i[4:2];
  assign legal = f4 <= 4'd8;
  assign imm_val = ie ? {{(DATA_W-5){instr_i[4]}}, instr_i[4:0]} : '0;
  // writeback in the same cycle is forwarded; r0 never forwards
  assign rs1_val = rs1 == 3'd0 ? '0 : (wb_en_i && wb_rd_i == rs1) ? wb_data_i : rf_q[rs1];
  assign rs2_val = (ie || rs2 == 3'd0) ? '0 : (wb_en_i && wb_rd_i == rs2) ? wb_data_i : rf_q[rs2];
  assign wb_mask  = wb_en_i ? 8'd1 << wb_rd_i : 8'd0;
  assign pend_eff = pend_q & ~wb_mask;
  assign hazard   = pend_eff[rs1] | (!ie & pend_eff[rs2]) | pend_eff[rd];
  assign in_ready_o = !rst_i && !hazard && (!out_valid_q || out_ready_i);
  assign accept   = in_valid_i && in_ready_o;
  assign set_mask = (accept && legal && rd != 3'd0) ? 8'd1 << rd : 8'd0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      out_valid_q <= 1'b0;
      illegal_q <= 1'b0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      func4_q <= '0;
      imm_en_q <= 1'b0;
      rd_q <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      pend_q <= (pend_q & ~wb_mask) | set_mask;
      illegal_q <= accept && !legal;
      if (wb_en_i && wb_rd_i != 3'd0) rf_q[wb_rd_i] <= wb_data_i;
      if (accept && legal) begin
        out_valid_q <= 1'b1;
        rs1_q <= rs1_val;
        rs2_q <= rs2_val;
        imm_q <= imm_val;
        func4_q <= f4;
        imm_en_q <= ie;
        rd_q <= rd;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end
  assign rs1_data_o  = rs1_q;
  assign rs2_data_o  = rs2_q;
  assign imm_o       = imm_q;
  assign func4_o     = func4_q;
  assign imm_en_o    = imm_en_q;
  assign rd_o        = rd_q;
  assign out_valid_o = out_valid_q;
  assign illegal_o   = illegal_q;
  assign busy_o      = |pend_q;
endmodule
